adder_bist_checker: RTL and testbench

ADDER_BIST_CHECKER -- requirements
Module: adder_bist_checker

---
 rtl/adder_bist_checker.sv | 107 ++++++++++
 tb/tb_adder_bist_checker.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/adder_bist_checker.sv
// Built-in self test for a 4-bit adder: sweeps all 512 {Cin, A, B} vectors,
// counts mismatches and captures the first failing vector.
module adder_bist_checker #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [3:0] A,
  output logic [3:0] B,
  output logic       Cin,
  input  logic [3:0] sum,
  input  logic       Cout,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [9:0] err_count,
  output logic       fail_valid,
  output logic [3:0] fail_A,
  output logic [3:0] fail_B,
  output logic       fail_Cin
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [3:0] HoldMax = 4'(SETTLE);

  state_e     state;
  logic [8:0] vec;
  logic [3:0] hold;
  logic [4:0] expected;
  logic       mismatch;
  logic       last_hold;

  // The vector register drives the operands directly; it is zero outside RUN.
  assign Cin = vec[8];
  assign A   = vec[7:4];
  assign B   = vec[3:0];

  always_comb begin
    expected  = {1'b0, A} + {1'b0, B} + {4'b0000, Cin};
    mismatch  = ({Cout, sum} != expected);
    last_hold = (hold == HoldMax);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= StIdle;
      vec        <= '0;
      hold       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_A     <= '0;
      fail_B     <= '0;
      fail_Cin   <= 1'b0;
    end else begin
      case (state)
        StIdle, StDone: begin
          if (start) begin
            state      <= StRun;
            vec        <= '0;
            hold       <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_A     <= '0;
            fail_B     <= '0;
            fail_Cin   <= 1'b0;
          end
        end
        StRun: begin
          if (!last_hold) begin
            hold <= hold + 4'd1;
          end else begin
            hold <= '0;
            if (mismatch) begin
              err_count <= err_count + 10'd1;
              if (!fail_valid) begin
                fail_valid <= 1'b1;
                fail_A     <= A;
                fail_B     <= B;
                fail_Cin   <= Cin;
              end
            end
            if (vec == 9'd511) begin
              state <= StDone;
              vec   <= '0;
              busy  <= 1'b0;
              done  <= 1'b1;
              // Include the final vector's own result in the verdict.
              pass  <= (err_count == 10'd0) && !mismatch;
            end else begin
              vec <= vec + 9'd1;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_bist_checker.sv
// Bench for adder_bist_checker: drives a fault-injectable adder model and
// compares results against a vector-sweep reference computed in the bench.
module tb_adder_bist_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start1 = 1'b0;
  logic start0 = 1'b0;

  int mode = 0;
  int p1 = 0;
  int p2 = 0;
  int tests = 0;
  int fails = 0;

  logic [3:0] a1, b1, sum1, fa1, fb1;
  logic       cin1, cout1, busy1, done1, pass1, fv1, fc1;
  logic [9:0] err1;
  logic [3:0] a0, b0, sum0, fa0, fb0;
  logic       cin0, cout0, busy0, done0, pass0, fv0, fc0;
  logic [9:0] err0;

  always #5 clk = ~clk;

  // Adder under test with an optional injected fault.
  function automatic logic [4:0] adder_model(input logic [3:0] a, input logic [3:0] b,
                                             input logic c, input int m, input int q1,
                                             input int q2);
    logic [4:0] good;
    int         v;
    good = 5'(int'(a) + int'(b) + int'(c));
    v    = int'(c) * 256 + int'(a) * 16 + int'(b);
    case (m)
      1:       return good & ~(5'd1 << q1);
      2:       return good | (5'd1 << q1);
      3:       return ((v % (q1 + 3)) == q2) ? (good ^ 5'd1) : good;
      default: return good;
    endcase
  endfunction

  assign {cout1, sum1} = adder_model(a1, b1, cin1, mode, p1, p2);
  assign {cout0, sum0} = adder_model(a0, b0, cin0, 0, 0, 0);

  adder_bist_checker #(.SETTLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .A(a1), .B(b1), .Cin(cin1), .sum(sum1),
    .Cout(cout1), .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .fail_valid(fv1), .fail_A(fa1), .fail_B(fb1), .fail_Cin(fc1)
  );

  adder_bist_checker #(.SETTLE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .A(a0), .B(b0), .Cin(cin0), .sum(sum0),
    .Cout(cout0), .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .fail_valid(fv0), .fail_A(fa0), .fail_B(fb0), .fail_Cin(fc0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs1();
    return {a1, b1, cin1, busy1, done1, pass1, err1, fv1, fa1, fb1, fc1};
  endfunction

  function automatic logic [31:0] outs0();
    return {a0, b0, cin0, busy0, done0, pass0, err0, fv0, fa0, fb0, fc0};
  endfunction

  // Reference: walk all 512 vectors in sweep order and score the adder.
  task automatic ref_model(output int errs, output logic fv, output logic [3:0] fa,
                           output logic [3:0] fb, output logic fc);
    errs = 0; fv = 0; fa = 0; fb = 0; fc = 0;
    for (int v = 0; v < 512; v++) begin
      int ra, rb, rc;
      rc = v / 256; ra = (v / 16) % 16; rb = v % 16;
      if (int'(adder_model(4'(ra), 4'(rb), 1'(rc), mode, p1, p2)) != ra + rb + rc) begin
        if (errs == 0) begin
          fv = 1; fa = 4'(ra); fb = 4'(rb); fc = 1'(rc);
        end
        errs++;
      end
    end
  endtask

  // Start a run on the SETTLE=1 instance and return edges until done.
  task automatic run1(input string tag, input bit hold_start, output int n);
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_busy_at_start"}, 32'(busy1), 32'd1);
    check({tag, "_cleared_at_start"}, {done1, pass1, err1, fv1, fa1, fb1, fc1}, 32'd0);
    if (!hold_start) start1 = 1'b0;
    n = 0;
    while (!done1 && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    start1 = 1'b0;
  endtask

  task automatic check_results(input string tag);
    int         errs;
    logic       fv, fc;
    logic [3:0] fa, fb;
    ref_model(errs, fv, fa, fb, fc);
    check({tag, "_err_count"}, 32'(err1), 32'(errs));
    check({tag, "_pass"}, 32'(pass1), 32'(errs == 0));
    check({tag, "_fail_capture"}, {fv1, fa1, fb1, fc1}, {fv, fa, fb, fc});
    check({tag, "_idle_outputs"}, {a1, b1, cin1, busy1, done1}, {9'd0, 1'b0, 1'b1});
  endtask

  initial begin
    int n;
    int done_seen;

    // Reset state
    #12;
    check("reset_outs_dut1", outs1(), 32'd0);
    check("reset_outs_dut0", outs0(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_no_start", outs1(), 32'd0);

    // Correct adder
    mode = 0;
    run1("good", 1'b0, n);
    check("good_latency", 32'(n), 32'd1024);
    check_results("good");
    repeat (5) @(posedge clk);
    #1;
    check("done_held", {done1, pass1, err1}, {1'b1, 1'b1, 10'd0});

    // sum[0] stuck at 0, restarted straight from DONE
    mode = 1; p1 = 0;
    run1("sum0_sa0", 1'b0, n);
    check("sum0_sa0_latency", 32'(n), 32'd1024);
    check_results("sum0_sa0");
    check("sum0_sa0_fixed", {err1, fa1, fb1, fc1}, {10'd256, 4'd0, 4'd1, 1'b0});

    // Cout stuck at 0
    mode = 1; p1 = 4;
    run1("cout_sa0", 1'b0, n);
    check_results("cout_sa0");
    check("cout_sa0_fixed", {err1, fa1, fb1, fc1}, {10'd256, 4'd1, 4'd15, 1'b0});

    // Randomized faults
    for (int i = 0; i < 5; i++) begin
      mode = int'($urandom_range(0, 3));
      p1   = int'($urandom_range(0, 4));
      p2   = int'($urandom_range(0, 2));
      run1("rand", 1'b0, n);
      check("rand_latency", 32'(n), 32'd1024);
      check_results("rand");
    end

    // start held high through RUN must not restart
    mode = 0;
    run1("start_held", 1'b1, n);
    check("start_held_latency", 32'(n), 32'd1024);
    check_results("start_held");

    // Reset in the middle of a failing run
    mode = 1; p1 = 0;
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    repeat (300) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrun_reset_outs", outs1(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int k = 0; k < 1100; k++) begin
      @(posedge clk);
      #1;
      if (done1 || busy1) done_seen++;
    end
    check("no_done_after_reset", 32'(done_seen), 32'd0);
    mode = 0;
    run1("after_reset", 1'b0, n);
    check("after_reset_latency", 32'(n), 32'd1024);
    check_results("after_reset");

    // SETTLE=0 instance
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    n = 0;
    while (!done0 && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("settle0_latency", 32'(n), 32'd512);
    check("settle0_results", {pass0, err0, fv0}, {1'b1, 10'd0, 1'b0});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
